// File: rtl/imem_fetch.sv
// Instruction fetch memory with a fixed read latency and an in-order
// response buffer. Requests are decoded and the memory is read at the
// acceptance edge. Each result waits in the buffer until its latency has
// elapsed and the consumer takes it.
module imem_fetch #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned BYTE_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instr,
  output logic [1:0]               rsp_fault,
  input  logic                     flush,
  input  logic                     prog_en,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_data
);

  localparam int unsigned NBUF   = READ_LAT + 1;
  localparam int unsigned PTR_W  = $clog2(NBUF);
  localparam int unsigned CNT_W  = $clog2(NBUF + 1);
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } fault_e;

  // Power-up contents are zero; only prog_en ever changes a word.
  logic [XLEN-1:0]  mem_q [DEPTH] = '{default: '0};

  logic [XLEN-1:0]  data_q  [NBUF];
  logic [XLEN-1:0]  data_d  [NBUF];
  fault_e           fault_q [NBUF];
  fault_e           fault_d [NBUF];
  logic [1:0]       lat_q   [NBUF];
  logic [1:0]       lat_d   [NBUF];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [ADDR_W-1:0] word_idx;
  logic              misalign;
  logic              out_of_range;
  logic [XLEN-1:0]   new_data;
  fault_e            new_fault;
  logic              accept;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake signals; ready never looks at req_valid.
  always_comb begin
    req_ready = !rst && !flush && !prog_en && (count_q < CNT_W'(NBUF));
    rsp_valid = !rst && (count_q != '0) && (lat_q[rd_ptr_q] == 2'd0);
    rsp_instr = rsp_valid ? data_q[rd_ptr_q] : '0;
    rsp_fault = rsp_valid ? fault_q[rd_ptr_q] : FLT_OK;
    accept    = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready;
  end

  // Address decode and memory read; misalignment outranks the range check.
  always_comb begin
    word_idx     = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
    misalign     = (BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00);
    out_of_range = 64'(word_idx) >= 64'(DEPTH);
    new_data     = '0;
    new_fault    = FLT_OK;
    if (misalign) begin
      new_fault = FLT_MISALIGN;
    end else if (out_of_range) begin
      new_fault = FLT_RANGE;
    end else begin
      new_data = mem_q[MEM_AW'(word_idx)];
    end
  end

  // Buffer next state: age every entry, push on accept, pop on transfer.
  always_comb begin
    data_d   = data_q;
    fault_d  = fault_q;
    lat_d    = lat_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (lat_q[i] != 2'd0) lat_d[i] = lat_q[i] - 2'd1;
    end
    if (accept) begin
      data_d[wr_ptr_q]  = new_data;
      fault_d[wr_ptr_q] = new_fault;
      lat_d[wr_ptr_q]   = 2'(READ_LAT - 1);
      wr_ptr_d          = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
    // A response popped in the flush cycle is still delivered; everything
    // left behind is dropped.
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Buffer state register; payload needs no reset since count gates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
    data_q  <= data_d;
    fault_q <= fault_d;
    lat_q   <= lat_d;
  end

  // Program port; reset blocks writes but never clears contents.
  always_ff @(posedge clk) begin
    if (prog_en && !rst) mem_q[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: one default instance (READ_LAT=1) and one
// with READ_LAT=3. Inputs change 1 time unit after a rising edge and outputs
// are checked 1 unit later.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  logic [31:0] req_addr_a, rsp_instr_a, prog_data_a;
  logic [1:0]  rsp_fault_a;
  logic        flush_a, prog_en_a;
  logic [7:0]  prog_addr_a;

  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [31:0] req_addr_b, rsp_instr_b, prog_data_b;
  logic [1:0]  rsp_fault_b;
  logic        flush_b, prog_en_b;
  logic [7:0]  prog_addr_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_fetch u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_instr(rsp_instr_a), .rsp_fault(rsp_fault_a),
    .flush(flush_a), .prog_en(prog_en_a),
    .prog_addr(prog_addr_a), .prog_data(prog_data_a)
  );

  imem_fetch #(.READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_instr(rsp_instr_b), .rsp_fault(rsp_fault_b),
    .flush(flush_b), .prog_en(prog_en_b),
    .prog_addr(prog_addr_b), .prog_data(prog_data_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_a(input logic [7:0] addr, input logic [31:0] data);
    prog_en_a = 1'b1; prog_addr_a = addr; prog_data_a = data;
    tick();
    prog_en_a = 1'b0;
  endtask

  task automatic prog_b(input logic [7:0] addr, input logic [31:0] data);
    prog_en_b = 1'b1; prog_addr_b = addr; prog_data_b = data;
    tick();
    prog_en_b = 1'b0;
  endtask

  // Single fetch on instance A; response expected right after acceptance.
  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_i,
                         input logic [1:0] exp_f, input string tag);
    req_valid_a = 1'b1; req_addr_a = addr; rsp_ready_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(rsp_valid_a), 32'd1);
    check({tag, "_instr"}, rsp_instr_a, exp_i);
    check({tag, "_fault"}, 32'(rsp_fault_a), 32'(exp_f));
    tick();
    #1;
  endtask

  // Single fetch on instance B with exact three-cycle latency checks.
  task automatic fetch_b(input logic [31:0] addr, input logic [31:0] exp_i, input string tag);
    req_valid_b = 1'b1; req_addr_b = addr; rsp_ready_b = 1'b1;
    tick();
    req_valid_b = 1'b0;
    #1;
    check({tag, "_lat0"}, 32'(rsp_valid_b), 32'd0);
    tick(); #1;
    check({tag, "_lat1"}, 32'(rsp_valid_b), 32'd0);
    tick(); #1;
    check({tag, "_valid"}, 32'(rsp_valid_b), 32'd1);
    check({tag, "_instr"}, rsp_instr_b, exp_i);
    check({tag, "_fault"}, 32'(rsp_fault_b), 32'd0);
    tick(); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int seen;
    bit resumed;
    bit acc_now;
    logic [31:0] q[$];

    rst = 1'b1;
    req_valid_a = 1'b0; req_addr_a = '0; rsp_ready_a = 1'b0;
    flush_a = 1'b0; prog_en_a = 1'b0; prog_addr_a = '0; prog_data_a = '0;
    req_valid_b = 1'b0; req_addr_b = '0; rsp_ready_b = 1'b0;
    flush_b = 1'b0; prog_en_b = 1'b0; prog_addr_b = '0; prog_data_b = '0;

    // Reset state; a write attempted during reset must be ignored.
    tick(); tick();
    prog_en_a = 1'b1; prog_addr_a = 8'd5; prog_data_a = 32'hBADBAD00;
    req_valid_a = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready_a), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_rsp_instr", rsp_instr_a, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault_a), 32'd0);
    check("rst_rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    tick();
    prog_en_a = 1'b0; req_valid_a = 1'b0; rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready_a), 32'd1);
    check("ready_after_rst_b", 32'(req_ready_b), 32'd1);

    prog_en_a = 1'b1; prog_addr_a = 8'd0; prog_data_a = 32'h20080020;
    #1;
    check("prog_blocks_ready", 32'(req_ready_a), 32'd0);
    tick(); prog_en_a = 1'b0;
    prog_a(8'd1, 32'h20090037);
    prog_a(8'd2, 32'h200A0044);
    for (int i = 0; i < 6; i++) prog_b(8'(i), 32'hB0000000 + 32'(i));

    // Back-to-back fetches of words 0 and 1.
    rsp_ready_a = 1'b1; req_valid_a = 1'b1; req_addr_a = 32'h0;
    tick();
    req_addr_a = 32'h4;
    #1;
    check("b2b0_valid", 32'(rsp_valid_a), 32'd1);
    check("b2b0_instr", rsp_instr_a, 32'h20080020);
    check("b2b0_fault", 32'(rsp_fault_a), 32'd0);
    check("b2b0_ready", 32'(req_ready_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    #1;
    check("b2b1_valid", 32'(rsp_valid_a), 32'd1);
    check("b2b1_instr", rsp_instr_a, 32'h20090037);
    check("b2b1_fault", 32'(rsp_fault_a), 32'd0);
    tick(); #1;
    check("b2b_drained", 32'(rsp_valid_a), 32'd0);

    // Faults and range boundaries.
    fetch_a(32'h2,   32'h0, 2'b01, "mis2");
    fetch_a(32'h400, 32'h0, 2'b10, "oor400");
    fetch_a(32'h402, 32'h0, 2'b01, "mis402");
    fetch_a(32'h3FC, 32'h0, 2'b00, "last_word");
    fetch_a(32'h14,  32'h0, 2'b00, "rst_prog_ignored");

    // Write after acceptance: the held response keeps the old word.
    rsp_ready_a = 1'b0; req_valid_a = 1'b1; req_addr_a = 32'h8;
    tick();
    req_valid_a = 1'b0;
    prog_en_a = 1'b1; prog_addr_a = 8'd2; prog_data_a = 32'hDEADBEEF;
    #1;
    check("old_valid", 32'(rsp_valid_a), 32'd1);
    check("old_instr", rsp_instr_a, 32'h200A0044);
    tick();
    prog_en_a = 1'b0;
    #1;
    check("hold_valid", 32'(rsp_valid_a), 32'd1);
    check("hold_instr", rsp_instr_a, 32'h200A0044);
    rsp_ready_a = 1'b1;
    tick(); #1;
    check("old_drained", 32'(rsp_valid_a), 32'd0);
    fetch_a(32'h8, 32'hDEADBEEF, 2'b00, "refetch8");

    // Reset with two responses outstanding.
    rsp_ready_a = 1'b0; req_valid_a = 1'b1; req_addr_a = 32'h0;
    tick();
    req_addr_a = 32'h4;
    #1;
    check("one_outst_ready", 32'(req_ready_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    #1;
    check("full_ready_a", 32'(req_ready_a), 32'd0);
    check("full_head_instr", rsp_instr_a, 32'h20080020);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(rsp_valid_a), 32'd0);
    check("midrst_instr", rsp_instr_a, 32'd0);
    check("midrst_ready", 32'(req_ready_a), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst_valid", 32'(rsp_valid_a), 32'd0);
    check("postrst_ready", 32'(req_ready_a), 32'd1);
    fetch_a(32'h0, 32'h20080020, 2'b00, "postrst_w0");
    fetch_a(32'h4, 32'h20090037, 2'b00, "postrst_w1");
    fetch_a(32'h8, 32'hDEADBEEF, 2'b00, "postrst_w2");

    // READ_LAT=3: latency, then fill to four outstanding with rsp_ready low.
    fetch_b(32'h8, 32'hB0000002, "lat3");
    rsp_ready_b = 1'b0; req_valid_b = 1'b1; req_addr_b = 32'h0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready_b) acc++;
      tick();
      req_addr_b = 32'(acc * 4);
      #1;
    end
    check("acc_count", 32'(acc), 32'd4);
    check("full_ready_b", 32'(req_ready_b), 32'd0);
    rsp_ready_b = 1'b1;
    #1;
    check("no_passthru", 32'(req_ready_b), 32'd0);
    resumed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid_b && rsp_ready_b) q.push_back(rsp_instr_b);
      acc_now = req_valid_b && req_ready_b;
      tick();
      if (acc_now) begin
        resumed = 1'b1;
        req_valid_b = 1'b0;
      end
      #1;
    end
    check("rsp_count", 32'(q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("order%0d", k), (k < q.size()) ? q[k] : 32'hFFFFFFFF,
            32'hB0000000 + 32'(k));
    end
    check("resumed", 32'(resumed), 32'd1);

    // Flush with three in flight, programming word 5 in the same cycle.
    rsp_ready_b = 1'b0; req_valid_b = 1'b1; req_addr_b = 32'h0;
    tick(); req_addr_b = 32'h4;
    tick(); req_addr_b = 32'h8;
    tick();
    req_valid_b = 1'b0;
    flush_b = 1'b1; prog_en_b = 1'b1; prog_addr_b = 8'd5; prog_data_b = 32'hF1F1F1F1;
    #1;
    check("preflush_instr", rsp_instr_b, 32'hB0000000);
    check("flush_ready", 32'(req_ready_b), 32'd0);
    tick();
    flush_b = 1'b0; prog_en_b = 1'b0; rsp_ready_b = 1'b1;
    #1;
    check("postflush_valid", 32'(rsp_valid_b), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_b) seen++;
      tick(); #1;
    end
    check("no_stale", 32'(seen), 32'd0);
    fetch_b(32'h4, 32'hB0000001, "after_flush");
    fetch_b(32'h14, 32'hF1F1F1F1, "flush_prog");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter XLEN, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 256, number of instruction words stored; legal 2..65536.
REQ-003 Parameter ADDR_W, default 32, request address width in bits.
REQ-004 Parameter READ_LAT, default 1, cycles from request acceptance to response valid; legal 1..4.
REQ-005 Parameter BYTE_ADDR, default 1: 1 = byte address (word index = addr>>2); 0 = word index = addr.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  fetch request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_addr  input  ADDR_W  fetch address.
REQ-011 rsp_valid  output  1  response word present.
REQ-012 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-013 rsp_instr  output  XLEN  fetched instruction word.
REQ-014 rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range.
REQ-015 flush  input  1  discard every in-flight and queued response.
REQ-016 prog_en  input  1  write prog_data to memory this cycle.
REQ-017 prog_addr  input  clog2(DEPTH)  word index written.
REQ-018 prog_data  input  XLEN  word written.

Function
REQ-019 A request transfers on a rising edge where req_valid and req_ready are both 1; a response transfers where rsp_valid and rsp_ready are both 1.
REQ-020 Memory is read at the acceptance edge; the response for an accepted request becomes eligible exactly READ_LAT cycles later when no earlier response is pending.
REQ-021 Responses are returned strictly in acceptance order.
REQ-022 Outstanding count = requests accepted and not yet transferred as responses; max outstanding = READ_LAT+1, held in an internal response buffer of READ_LAT+1 entries.
REQ-023 req_ready = !rst && !flush && !prog_en && (outstanding < READ_LAT+1); req_ready has no combinational dependence on req_valid.
REQ-024 Acceptance and response transfer in the same cycle at full occupancy: the response frees a slot only for the next cycle (no same-cycle pass-through).
REQ-025 rsp_valid, rsp_instr, rsp_fault remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 BYTE_ADDR=1 and req_addr[1:0]!=0: rsp_fault=01, rsp_instr=0; misalignment takes priority over range.
REQ-027 Word index >= DEPTH: rsp_fault=10, rsp_instr=0; index never wraps.
REQ-028 Faulted requests occupy the same latency and buffer slot as good requests.
REQ-029 prog_en=1: memory[prog_addr] <= prog_data at that edge; requests accepted earlier return the pre-write contents.
REQ-030 flush=1: at that edge outstanding returns to 0, buffer empties, rsp_valid=0 next cycle; a response transferring in the flush cycle still counts as delivered.
REQ-031 flush and prog_en in the same cycle: both take effect.
REQ-032 Memory contents are 0 at time zero and never altered except through prog_en.

Reset
REQ-033 While rst=1: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_fault=00, outstanding=0, buffer empty.
REQ-034 req_ready may assert on the first cycle after rst deasserts; reset mid-operation discards all outstanding responses.
REQ-035 Reset does not alter memory contents; prog_en is ignored while rst=1.

Verification
REQ-036 Defaults; program word 0=32'h20080020, 1=32'h20090037; fetch addr 0 then 4 back-to-back, rsp_ready=1 -> rsp_instr 32'h20080020 at cycle+1, 32'h20090037 at cycle+2, fault 00.
REQ-037 READ_LAT=3, rsp_ready=0, req_valid held -> exactly 4 accepted, req_ready low; raise rsp_ready -> 4 in-order responses, then acceptance resumes.
REQ-038 Fetch addr 32'h2 -> fault 01, instr 0; fetch addr 32'h400 (DEPTH=256) -> fault 10, instr 0; fetch 32'h402 -> fault 01.
REQ-039 Three requests in flight, pulse flush -> rsp_valid=0 next cycle, no stale response ever appears, next fetch of addr 4 returns word 1.
REQ-040 Fetch addr 8 accepted, prog_en writes word 2=32'hDEADBEEF next cycle -> response shows old word; refetch returns 32'hDEADBEEF.
REQ-041 Assert rst with 2 outstanding -> rsp_valid=0 while in reset, memory unchanged afterward (refetch returns programmed words).
